// File: rtl/z180_bus_pkg.sv
// Shared types and constants for the Z8S180 memory bus controller.
package z180_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAITST = 2'd1,
    ACTIVE = 2'd2,
    HOLD   = 2'd3
  } bus_state_t;

  localparam logic [7:0] CFG_PORT_DEF = 8'hFE;
  localparam int         WCNT_W       = 4;

endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchronizer for active-low CPU strobes; resets to the inactive (all-ones) level.
module strobe_sync #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/z180_mem_ctl.sv
// Z8S180 bus-cycle controller: decodes memory cycles to boot ROM or SRAM,
// drives SRAM strobes, ROM enable, wait states and the sticky boot overlay.
module z180_mem_ctl
  import z180_bus_pkg::*;
#(
  parameter int         ROM_ADDR_BITS = 9,
  parameter int         WAIT_ROM      = 0,
  parameter int         WAIT_SRAM     = 1,
  parameter logic [7:0] CFG_PORT      = CFG_PORT_DEF
) (
  input  logic        hwclk,
  input  logic        reset,
  input  logic [19:0] a,
  input  logic [7:0]  d_in,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic        rfsh_n,
  output logic        rom_oe,
  output logic        ce_n,
  output logic        oe_n,
  output logic        we_n,
  output logic        wait_n,
  output logic        boot_en
);

  localparam logic [WCNT_W-1:0] W_ROM  = WCNT_W'(WAIT_ROM);
  localparam logic [WCNT_W-1:0] W_SRAM = WCNT_W'(WAIT_SRAM);

  logic [5:0] s;
  logic       s_mreq_n, s_iorq_n, s_rd_n, s_wr_n, s_m1_n, s_rfsh_n;

  strobe_sync #(.W(6)) u_sync (
    .clk (hwclk),
    .rst (reset),
    .d   ({mreq_n, iorq_n, rd_n, wr_n, m1_n, rfsh_n}),
    .q   (s)
  );
  assign {s_mreq_n, s_iorq_n, s_rd_n, s_wr_n, s_m1_n, s_rfsh_n} = s;

  bus_state_t        state, st_nx;
  logic [WCNT_W-1:0] cnt, cnt_nx;
  logic              tgt_rom, rom_nx;
  logic              is_wr, wr_nx;
  logic              boot_nx;
  logic              hit_rom, busy;
  logic              unused_ok;

  assign hit_rom   = boot_en && (a[19:ROM_ADDR_BITS] == '0);
  assign unused_ok = ^{a, d_in[7:1]};

  always_comb begin
    st_nx   = state;
    cnt_nx  = cnt;
    rom_nx  = tgt_rom;
    wr_nx   = is_wr;
    boot_nx = boot_en;
    case (state)
      IDLE: begin
        // Target is latched only here, so a boot_en clear never retargets a live cycle.
        if (!s_mreq_n) begin
          if (!s_rfsh_n) begin
            st_nx = HOLD;
          end else if (!s_rd_n || !s_wr_n) begin
            rom_nx = !s_rd_n && hit_rom;
            wr_nx  = s_rd_n;
            cnt_nx = rom_nx ? W_ROM : W_SRAM;
            st_nx  = (cnt_nx != '0) ? WAITST : ACTIVE;
          end
        end else if (!s_iorq_n) begin
          if (s_m1_n && !s_wr_n && a[7:0] == CFG_PORT && d_in[0])
            boot_nx = 1'b0;
          st_nx = HOLD;
        end
      end
      WAITST: begin
        cnt_nx = cnt - 1'b1;
        if (s_mreq_n) begin
          st_nx  = IDLE;
          cnt_nx = '0;
        end else if (cnt == WCNT_W'(1)) begin
          st_nx = ACTIVE;
        end
      end
      ACTIVE: if (s_mreq_n) st_nx = IDLE;
      HOLD:   if (s_mreq_n && s_iorq_n) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  // Outputs are registered straight from the next state so they change on the same edge.
  assign busy = (st_nx == WAITST) || (st_nx == ACTIVE);

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      tgt_rom <= 1'b0;
      is_wr   <= 1'b0;
      boot_en <= 1'b1;
      rom_oe  <= 1'b0;
      ce_n    <= 1'b1;
      oe_n    <= 1'b1;
      we_n    <= 1'b1;
      wait_n  <= 1'b1;
    end else begin
      state   <= st_nx;
      cnt     <= cnt_nx;
      tgt_rom <= rom_nx;
      is_wr   <= wr_nx;
      boot_en <= boot_nx;
      rom_oe  <= busy && rom_nx;
      ce_n    <= !(busy && !rom_nx);
      oe_n    <= !(busy && !rom_nx && !wr_nx);
      we_n    <= !(st_nx == ACTIVE && !rom_nx && wr_nx);
      wait_n  <= (st_nx != WAITST);
    end
  end

endmodule

// File: tb/tb_z180_mem_ctl.sv
// Directed bench for z180_mem_ctl: ROM/SRAM decode, wait states, overlay control, abort, reset.
module tb_z180_mem_ctl;

  logic        hwclk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] a     = '0;
  logic [7:0]  d_in  = '0;
  logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1, rfsh_n = 1'b1;
  logic        rom_oe, ce_n, oe_n, we_n, wait_n, boot_en;

  z180_mem_ctl #(
    .ROM_ADDR_BITS (9),
    .WAIT_ROM      (0),
    .WAIT_SRAM     (3),
    .CFG_PORT      (8'hFE)
  ) dut (
    .hwclk   (hwclk),
    .reset   (reset),
    .a       (a),
    .d_in    (d_in),
    .mreq_n  (mreq_n),
    .iorq_n  (iorq_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .m1_n    (m1_n),
    .rfsh_n  (rfsh_n),
    .rom_oe  (rom_oe),
    .ce_n    (ce_n),
    .oe_n    (oe_n),
    .we_n    (we_n),
    .wait_n  (wait_n),
    .boot_en (boot_en)
  );

  always #20 hwclk = ~hwclk;

  int n_chk = 0, n_fail = 0;

  // Running per-cycle activity counters, sampled just after each rising edge.
  int n_wait = 0, n_ce = 0, n_oe = 0, n_we = 0, n_rom = 0, n_ovl = 0;
  int b_wait, b_ce, b_oe, b_we, b_rom, b_ovl;
  int d_wait, d_ce, d_oe, d_we, d_rom, d_ovl;

  always @(posedge hwclk) begin
    #1;
    if (!wait_n) n_wait++;
    if (!ce_n)   n_ce++;
    if (!oe_n)   n_oe++;
    if (!we_n)   n_we++;
    if (rom_oe)  n_rom++;
    if (!we_n && !wait_n) n_ovl++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    b_wait = n_wait; b_ce = n_ce; b_oe = n_oe; b_we = n_we; b_rom = n_rom; b_ovl = n_ovl;
  endtask

  task automatic delta();
    d_wait = n_wait - b_wait; d_ce = n_ce - b_ce; d_oe = n_oe - b_oe;
    d_we = n_we - b_we; d_rom = n_rom - b_rom; d_ovl = n_ovl - b_ovl;
  endtask

  task automatic mem_cyc(input logic [19:0] addr, input bit wr, input logic [7:0] dat, input int hold);
    snap();
    a = addr; d_in = dat;
    @(negedge hwclk);
    mreq_n = 1'b0;
    if (wr) wr_n = 1'b0; else rd_n = 1'b0;
    repeat (hold) @(negedge hwclk);
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    repeat (6) @(negedge hwclk);
    delta();
  endtask

  task automatic io_wr(input logic [7:0] port, input logic [7:0] dat);
    snap();
    a = {12'h000, port}; d_in = dat;
    @(negedge hwclk);
    iorq_n = 1'b0; wr_n = 1'b0;
    repeat (6) @(negedge hwclk);
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (6) @(negedge hwclk);
    delta();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rom_oe"}, rom_oe, 1'b0);
    chk({tag, "_ce_n"},   ce_n,   1'b1);
    chk({tag, "_wait_n"}, wait_n, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;

    // Reset state
    repeat (3) @(negedge hwclk);
    chk("rst_rom_oe",  rom_oe,  1'b0);
    chk("rst_ce_n",    ce_n,    1'b1);
    chk("rst_oe_n",    oe_n,    1'b1);
    chk("rst_we_n",    we_n,    1'b1);
    chk("rst_wait_n",  wait_n,  1'b1);
    chk("rst_boot_en", boot_en, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge hwclk);

    // ROM read in overlay, zero wait states
    snap();
    a = 20'h00010;
    @(negedge hwclk);
    mreq_n = 1'b0; rd_n = 1'b0;
    lat = 0;
    while (!rom_oe && lat < 10) begin @(negedge hwclk); lat++; end
    chk("rom_on_latency_ok", (lat >= 2 && lat <= 3), 1'b1);
    repeat (3) @(negedge hwclk);
    mreq_n = 1'b1; rd_n = 1'b1;
    lat = 0;
    while (rom_oe && lat < 10) begin @(negedge hwclk); lat++; end
    chk("rom_off_latency_ok", (lat <= 3), 1'b1);
    repeat (3) @(negedge hwclk);
    delta();
    chk("rom_rd_ce_low",   d_ce,   0);
    chk("rom_rd_wait_low", d_wait, 0);
    chk("rom_rd_seen",     (d_rom > 0), 1'b1);

    // SRAM read with 3 wait states
    mem_cyc(20'h12345, 1'b0, 8'h00, 10);
    chk("sram_rd_wait_cycles", d_wait, 3);
    chk("sram_rd_ce_seen",     (d_ce > 0), 1'b1);
    chk("sram_rd_oe_eq_ce",    d_oe, d_ce);
    chk("sram_rd_we_low",      d_we, 0);
    chk("sram_rd_rom_oe",      d_rom, 0);
    chk_idle("sram_rd_end");

    // Write into overlay window shadows to SRAM
    mem_cyc(20'h00020, 1'b1, 8'h5A, 10);
    chk("shadow_wr_rom_oe",  d_rom, 0);
    chk("shadow_wr_wait",    d_wait, 3);
    chk("shadow_wr_ce_seen", (d_ce > 0), 1'b1);
    chk("shadow_wr_we_seen", (d_we > 0), 1'b1);
    chk("shadow_wr_oe_low",  d_oe, 0);
    chk("shadow_wr_we_during_wait", d_ovl, 0);
    chk("shadow_wr_we_n_end", we_n, 1'b1);

    // Refresh cycle: no outputs
    snap();
    a = 20'h00010;
    @(negedge hwclk);
    mreq_n = 1'b0; rfsh_n = 1'b0;
    repeat (6) @(negedge hwclk);
    mreq_n = 1'b1; rfsh_n = 1'b1;
    repeat (6) @(negedge hwclk);
    delta();
    chk("rfsh_outputs", d_ce + d_rom + d_wait + d_we, 0);

    // Interrupt acknowledge: no outputs, no overlay change
    snap();
    a = 20'h000FE; d_in = 8'h01;
    @(negedge hwclk);
    iorq_n = 1'b0; m1_n = 1'b0;
    repeat (6) @(negedge hwclk);
    iorq_n = 1'b1; m1_n = 1'b1;
    repeat (6) @(negedge hwclk);
    delta();
    chk("intack_outputs", d_ce + d_rom + d_wait + d_we, 0);
    chk("intack_boot_en", boot_en, 1'b1);

    // Back in IDLE: another ROM read is served
    mem_cyc(20'h00010, 1'b0, 8'h00, 6);
    chk("post_hold_rom_seen", (d_rom > 0), 1'b1);
    chk("post_hold_rom_ce",   d_ce, 0);

    // Overlay control port
    io_wr(8'hFE, 8'h00);
    chk("cfg_d0_zero_keeps_boot", boot_en, 1'b1);
    io_wr(8'hFD, 8'h01);
    chk("other_port_keeps_boot", boot_en, 1'b1);
    io_wr(8'hFE, 8'h01);
    chk("cfg_clears_boot", boot_en, 1'b0);
    chk("cfg_io_no_mem", d_ce + d_rom + d_wait, 0);

    mem_cyc(20'h00010, 1'b0, 8'h00, 10);
    chk("noboot_rd_rom_oe", d_rom, 0);
    chk("noboot_rd_ce",     (d_ce > 0), 1'b1);
    chk("noboot_rd_oe",     (d_oe > 0), 1'b1);
    chk("noboot_rd_wait",   d_wait, 3);

    io_wr(8'hFE, 8'h00);
    chk("boot_stays_clear", boot_en, 1'b0);

    // Abort: mreq_n rises while still in the wait phase
    snap();
    a = 20'h12345;
    @(negedge hwclk);
    mreq_n = 1'b0; rd_n = 1'b0;
    repeat (2) @(negedge hwclk);
    mreq_n = 1'b1; rd_n = 1'b1;
    repeat (6) @(negedge hwclk);
    delta();
    chk("abort_wait_cycles", d_wait, 2);
    chk("abort_ce_cycles",   d_ce, 2);
    chk("abort_we",          d_we, 0);
    chk_idle("abort_end");

    // Reset during ACTIVE
    a = 20'h12345;
    @(negedge hwclk);
    mreq_n = 1'b0; rd_n = 1'b0;
    repeat (8) @(negedge hwclk);
    chk("pre_rst_active", {oe_n, wait_n}, 2'b01);
    #5 reset = 1'b1;
    #1;
    chk("midrst_oe_n",    oe_n,    1'b1);
    chk("midrst_boot_en", boot_en, 1'b1);
    chk_idle("midrst");
    mreq_n = 1'b1; rd_n = 1'b1;
    repeat (4) @(negedge hwclk);
    reset = 1'b0;
    repeat (4) @(negedge hwclk);
    chk_idle("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
